// File: rtl/emc_io_filt.sv
// emc_io_filt: board IO synchroniser/debouncer, event latch, axis enable/reset drive.
// Define EMC_IO_INTERLOCK_EN to make an alarm hold its axis disabled until that axis is reset.
module emc_io_filt #(
    parameter int N_AXIS    = 4,
    parameter int IO_W      = 16,
    parameter int DB_CYC    = 100,
    parameter int RST_PULSE = 50
) (
    input  logic                  clk_10M,
    input  logic                  n_rst,
    input  logic [N_AXIS-1:0]     EX_Alarm,
    input  logic [N_AXIS-1:0]     EX_Home,
    input  logic [2*N_AXIS-1:0]   EX_LimitPN,
    input  logic [IO_W-1:0]       EX_IO_Input,
    input  logic [IO_W-1:0]       F_IO_Output,
    input  logic [N_AXIS-1:0]     F_Axis_En,
    input  logic [N_AXIS-1:0]     F_Axis_Rst,
    input  logic [4*N_AXIS-1:0]   F_Evt_Clr,
    output logic [N_AXIS-1:0]     F_Alarm,
    output logic [N_AXIS-1:0]     F_Home,
    output logic [2*N_AXIS-1:0]   F_LimitPN,
    output logic [IO_W-1:0]       F_IO_Input,
    output logic [4*N_AXIS-1:0]   F_Evt,
    output logic [N_AXIS-1:0]     F_Trip,
    output logic [IO_W-1:0]       EX_IO_Output,
    output logic [N_AXIS-1:0]     EX_Enable,
    output logic [N_AXIS-1:0]     EX_Reset
);

    localparam int NIN = 3 * N_AXIS + IO_W;
    localparam int NEV = 4 * N_AXIS;
    localparam int CW  = $clog2(DB_CYC + 1);
    localparam int PW  = $clog2(RST_PULSE + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
    localparam logic [PW-1:0] PULSE_LEN = PW'(RST_PULSE);

    logic [NIN-1:0] pins;
    logic [NIN-1:0] meta;
    logic [NIN-1:0] sync;
    logic [NIN-1:0] filt;
    logic [NEV-1:0] filt_q;
    logic [CW-1:0]  cnt [NIN];

    // Bit order matches F_Evt: alarm, home, limit, then general IO on top.
    assign pins = {EX_IO_Input, EX_LimitPN, EX_Home, EX_Alarm};

    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            meta   <= '0;
            sync   <= '0;
            filt   <= '0;
            filt_q <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            meta   <= pins;
            sync   <= meta;
            filt_q <= filt[NEV-1:0];
            for (int i = 0; i < NIN; i++) begin
                if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign F_Alarm    = filt[N_AXIS-1:0];
    assign F_Home     = filt[2*N_AXIS-1:N_AXIS];
    assign F_LimitPN  = filt[NEV-1:2*N_AXIS];
    assign F_IO_Input = filt[NIN-1:NEV];

    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            F_Evt <= '0;
        end else begin
            F_Evt <= (F_Evt & ~F_Evt_Clr) | (filt[NEV-1:0] & ~filt_q);
        end
    end

    logic [N_AXIS-1:0] rreq;
    logic [N_AXIS-1:0] rreq_q;
    logic [N_AXIS-1:0] rload;
    logic [PW-1:0]     pcnt [N_AXIS];

    assign rload = rreq & ~rreq_q;

    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            rreq   <= '0;
            rreq_q <= '0;
            for (int i = 0; i < N_AXIS; i++) pcnt[i] <= '0;
        end else begin
            rreq   <= F_Axis_Rst;
            rreq_q <= rreq;
            for (int i = 0; i < N_AXIS; i++) begin
                if (rload[i]) begin
                    pcnt[i] <= PULSE_LEN;
                end else if (pcnt[i] != '0) begin
                    pcnt[i] <= pcnt[i] - PW'(1);
                end
            end
        end
    end

    always_comb begin
        EX_Reset = '0;
        for (int i = 0; i < N_AXIS; i++) EX_Reset[i] = (pcnt[i] != '0);
    end

    logic [N_AXIS-1:0] trip;

`ifdef EMC_IO_INTERLOCK_EN
    logic [N_AXIS-1:0] pend;
    logic [N_AXIS-1:0] trip_d;

    // A reload on the last pulse cycle keeps the pulse running, so no release.
    always_comb begin
        pend = '0;
        for (int i = 0; i < N_AXIS; i++) begin
            pend[i] = (pcnt[i] == PW'(1)) & ~rload[i];
        end
        trip_d = F_Alarm | (trip & ~pend);
    end

    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            trip <= '0;
        end else begin
            trip <= trip_d;
        end
    end
`else
    assign trip = '0;
`endif

    assign F_Trip = trip;

    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            EX_IO_Output <= '0;
            EX_Enable    <= '0;
        end else begin
            EX_IO_Output <= F_IO_Output;
            EX_Enable    <= F_Axis_En & ~trip;
        end
    end

endmodule

// File: tb/tb_emc_io_filt.sv
// tb_emc_io_filt: directed and random stimulus for emc_io_filt against a
// history-window reference model kept in the bench.
module tb_emc_io_filt;

    localparam int N    = 4;
    localparam int IOW  = 16;
    localparam int DB   = 4;
    localparam int PL   = 50;
    localparam int NIN  = 3 * N + IOW;
    localparam int NEV  = 4 * N;

`ifdef EMC_IO_INTERLOCK_EN
    localparam logic [N-1:0] EN_TRIP  = 4'hD;
    localparam logic [N-1:0] TRIP_EXP = 4'h2;
`else
    localparam logic [N-1:0] EN_TRIP  = 4'hF;
    localparam logic [N-1:0] TRIP_EXP = 4'h0;
`endif

    logic           clk_10M = 1'b0;
    logic           n_rst;
    logic [N-1:0]   EX_Alarm, EX_Home, F_Axis_En, F_Axis_Rst;
    logic [2*N-1:0] EX_LimitPN;
    logic [IOW-1:0] EX_IO_Input, F_IO_Output;
    logic [NEV-1:0] F_Evt_Clr;
    logic [N-1:0]   F_Alarm, F_Home, F_Trip, EX_Enable, EX_Reset;
    logic [2*N-1:0] F_LimitPN;
    logic [IOW-1:0] F_IO_Input, EX_IO_Output;
    logic [NEV-1:0] F_Evt;

    emc_io_filt #(
        .N_AXIS(N), .IO_W(IOW), .DB_CYC(DB), .RST_PULSE(PL)
    ) dut (
        .clk_10M(clk_10M), .n_rst(n_rst),
        .EX_Alarm(EX_Alarm), .EX_Home(EX_Home),
        .EX_LimitPN(EX_LimitPN), .EX_IO_Input(EX_IO_Input),
        .F_IO_Output(F_IO_Output), .F_Axis_En(F_Axis_En),
        .F_Axis_Rst(F_Axis_Rst), .F_Evt_Clr(F_Evt_Clr),
        .F_Alarm(F_Alarm), .F_Home(F_Home), .F_LimitPN(F_LimitPN),
        .F_IO_Input(F_IO_Input), .F_Evt(F_Evt), .F_Trip(F_Trip),
        .EX_IO_Output(EX_IO_Output), .EX_Enable(EX_Enable),
        .EX_Reset(EX_Reset)
    );

    always #5 clk_10M = ~clk_10M;

    int checks = 0;
    int errors = 0;

    logic [NIN-1:0] hist [$];
    logic [NIN-1:0] m_filt, m_filt1;
    logic [NEV-1:0] m_evt;
    logic [IOW-1:0] m_io;
    logic [N-1:0]   m_en, m_trip, r1, r2;
    int             m_end [N];
    int             cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (DB + 2) hist.push_back('0);
        m_filt = '0; m_filt1 = '0; m_evt = '0; m_io = '0;
        m_en = '0; m_trip = '0; r1 = '0; r2 = '0;
        for (int i = 0; i < N; i++) m_end[i] = 0;
    endtask

    // Filtered bit takes value v once the last DB synced samples all read v.
    task automatic model_edge();
        logic [NIN-1:0] f_n;
        logic [NEV-1:0] e_n;
        logic [N-1:0]   t_n, en_n, rise;
        logic           v;
        bit             same;
        cyc++;
        hist.push_front({EX_IO_Input, EX_LimitPN, EX_Home, EX_Alarm});
        if (hist.size() > DB + 2) void'(hist.pop_back());
        e_n  = (m_evt & ~F_Evt_Clr) | (m_filt[NEV-1:0] & ~m_filt1[NEV-1:0]);
        en_n = F_Axis_En & ~m_trip;
        rise = r1 & ~r2;
        t_n  = '0;
        for (int i = 0; i < N; i++) begin
`ifdef EMC_IO_INTERLOCK_EN
            t_n[i] = m_filt[i] |
                     (m_trip[i] & !((cyc == m_end[i]) && !rise[i]));
`endif
            if (rise[i]) m_end[i] = cyc + PL;
        end
        f_n = m_filt;
        for (int b = 0; b < NIN; b++) begin
            v = hist[2][b];
            same = 1'b1;
            for (int k = 3; k <= DB + 1; k++) if (hist[k][b] !== v) same = 1'b0;
            if (same && v !== m_filt[b]) f_n[b] = v;
        end
        m_filt1 = m_filt; m_filt = f_n; m_evt = e_n;
        m_en = en_n; m_trip = t_n; m_io = F_IO_Output;
        r2 = r1; r1 = F_Axis_Rst;
    endtask

    task automatic check_all();
        logic [N-1:0] rexp;
        for (int i = 0; i < N; i++) rexp[i] = (cyc < m_end[i]);
        chk("filt", {F_IO_Input, F_LimitPN, F_Home, F_Alarm}, m_filt);
        chk("evt", F_Evt, m_evt);
        chk("trip", F_Trip, m_trip);
        chk("io_out", EX_IO_Output, m_io);
        chk("enable", EX_Enable, m_en);
        chk("ex_reset", EX_Reset, rexp);
    endtask

    task automatic step();
        @(posedge clk_10M);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #3;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_10M);
        @(negedge clk_10M);
        n_rst = 1'b1;
    endtask

    int hi;
    logic [31:0] r;

    initial begin
        n_rst = 1'b0;
        EX_Alarm = '0; EX_Home = '0; EX_LimitPN = '0; EX_IO_Input = '0;
        F_IO_Output = '0; F_Axis_En = '0; F_Axis_Rst = '0; F_Evt_Clr = '0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_10M);
        @(negedge clk_10M);
        n_rst = 1'b1;

        F_IO_Output = 16'hA5C3;
        step();
        chk("io_a5c3", EX_IO_Output, 16'hA5C3);

        F_Axis_En = 4'hF;
        step();
        chk("en_plain", EX_Enable, 4'hF);
        EX_Alarm[1] = 1'b1;
        repeat (10) step();
        chk("en_alarm", EX_Enable, EN_TRIP);
        chk("trip_alarm", F_Trip, TRIP_EXP);
        EX_Alarm[1] = 1'b0;
        repeat (10) step();
        chk("en_hold", EX_Enable, EN_TRIP);
        F_Axis_Rst[1] = 1'b1;
        step();
        F_Axis_Rst[1] = 1'b0;
        repeat (60) step();
        chk("en_release", EX_Enable, 4'hF);

        EX_Home[0] = 1'b1;
        repeat (5) step();
        chk("home0_early", F_Home[0], 1'b0);
        step();
        chk("home0_lat", F_Home[0], 1'b1);
        chk("evt4_early", F_Evt[4], 1'b0);
        step();
        chk("evt4_lat", F_Evt[4], 1'b1);

        EX_Home[1] = 1'b1;
        repeat (3) step();
        EX_Home[1] = 1'b0;
        repeat (8) step();
        chk("home1_glitch", F_Home[1], 1'b0);
        chk("evt5_glitch", F_Evt[5], 1'b0);

        EX_Alarm[0] = 1'b1;
        repeat (7) step();
        chk("evt0_set", F_Evt[0], 1'b1);
        EX_Alarm[0] = 1'b0;
        repeat (8) step();
        EX_Alarm[0] = 1'b1;
        repeat (6) step();
        F_Evt_Clr[0] = 1'b1;
        step();
        chk("evt0_set_wins", F_Evt[0], 1'b1);
        step();
        chk("evt0_clr", F_Evt[0], 1'b0);
        F_Evt_Clr[0] = 1'b0;
        repeat (5) step();
        chk("evt0_held", F_Evt[0], 1'b0);

        hi = 0;
        F_Axis_Rst[2] = 1'b1;
        for (int n = 0; n < 70; n++) begin
            step();
            if (EX_Reset[2]) hi++;
        end
        chk("pulse_50", hi, 32'd50);
        F_Axis_Rst[2] = 1'b0;
        repeat (5) step();

        hi = 0;
        F_Axis_Rst[2] = 1'b1;
        step();
        F_Axis_Rst[2] = 1'b0;
        if (EX_Reset[2]) hi++;
        for (int n = 0; n < 29; n++) begin
            step();
            if (EX_Reset[2]) hi++;
        end
        F_Axis_Rst[2] = 1'b1;
        step();
        F_Axis_Rst[2] = 1'b0;
        if (EX_Reset[2]) hi++;
        for (int n = 0; n < 90; n++) begin
            step();
            if (EX_Reset[2]) hi++;
        end
        chk("pulse_retrig_80", hi, 32'd80);

        for (int n = 0; n < 600; n++) begin
            r = $urandom & $urandom & $urandom & $urandom;
            EX_Alarm ^= r[N-1:0];
            r = $urandom & $urandom & $urandom;
            EX_Home ^= r[N-1:0];
            EX_LimitPN ^= r[N+2*N-1:N];
            r = $urandom & $urandom & $urandom;
            EX_IO_Input ^= r[IOW-1:0];
            r = $urandom & $urandom & $urandom;
            F_Evt_Clr = r[NEV-1:0];
            r = $urandom & $urandom & $urandom & $urandom & $urandom;
            F_Axis_Rst ^= r[N-1:0];
            r = $urandom;
            F_IO_Output = r[IOW-1:0];
            if (n % 25 == 0) F_Axis_En = r[IOW+N-1:IOW];
            step();
        end

        EX_IO_Input = ~EX_IO_Input;
        EX_Home = ~EX_Home;
        repeat (2) step();
        async_reset();
        repeat (12) step();

        F_Axis_Rst = '0;
        repeat (3) step();
        F_Axis_Rst[0] = 1'b1;
        repeat (10) step();
        async_reset();
        repeat (70) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
